// File: rtl/vx_exec_route_arb.sv
// vx_exec_route_arb: execute-stage router.
// Steers one dispatch stream into NUM_UNITS first-word-fall-through FIFOs and merges the
// NUM_UNITS commit streams back into one registered commit port with round-robin fairness.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_unit/        dispatch handshake, target unit, ebreak flag, payload
//   in_ebreak/in_data
//   unit_valid/unit_ready/unit_data   per-unit FIFO heads (unit i at [i*DATA_WIDTH +: DATA_WIDTH])
//   unit_count                        per-unit FIFO occupancy
//   cmt_in_valid/ready/data           commit requests from the units, grant is one-hot or zero
//   cmt_out_valid/ready/data/unit     merged, registered commit port
//   bad_unit_err, sim_ebreak          sticky status flags, cleared only by reset
module vx_exec_route_arb #(
   parameter int unsigned NUM_UNITS   = 4,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned CDATA_WIDTH = 48,
   parameter int unsigned UNIT_BITS   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
   parameter int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [UNIT_BITS-1:0]             in_unit,
   input  logic                             in_ebreak,
   input  logic [DATA_WIDTH-1:0]            in_data,
   output logic [NUM_UNITS-1:0]             unit_valid,
   input  logic [NUM_UNITS-1:0]             unit_ready,
   output logic [NUM_UNITS*DATA_WIDTH-1:0]  unit_data,
   output logic [NUM_UNITS*CNT_W-1:0]       unit_count,
   input  logic [NUM_UNITS-1:0]             cmt_in_valid,
   output logic [NUM_UNITS-1:0]             cmt_in_ready,
   input  logic [NUM_UNITS*CDATA_WIDTH-1:0] cmt_in_data,
   output logic                             cmt_out_valid,
   input  logic                             cmt_out_ready,
   output logic [CDATA_WIDTH-1:0]           cmt_out_data,
   output logic [UNIT_BITS-1:0]             cmt_out_unit,
   output logic                             bad_unit_err,
   output logic                             sim_ebreak
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   // Dispatch FIFOs
   logic [DATA_WIDTH-1:0]           mem_q [NUM_UNITS][DEPTH];
   logic [NUM_UNITS-1:0][PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [NUM_UNITS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_UNITS-1:0]            full, push, pop;
   logic                            bad_unit, sel_full;

   // Out-of-range targets only exist when NUM_UNITS is not a power of two.
   if (NUM_UNITS < (1 << UNIT_BITS)) begin : g_range_chk
      assign bad_unit = (32'(in_unit) >= NUM_UNITS);
   end else begin : g_no_range_chk
      assign bad_unit = 1'b0;
   end

   always_comb begin
      sel_full = 1'b0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         full[i] = (cnt_q[i] == CNT_W'(DEPTH));
         if (in_unit == UNIT_BITS'(i)) sel_full = full[i];
      end
   end

   // Ready depends only on the registered full flag, never on a same-cycle pop.
   assign in_ready = reset_n && (bad_unit || !sel_full);

   always_comb begin
      push       = '0;
      pop        = '0;
      unit_valid = '0;
      unit_data  = '0;
      unit_count = '0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      for (int i = 0; i < NUM_UNITS; i++) begin
         push[i]       = in_valid && in_ready && !bad_unit && (in_unit == UNIT_BITS'(i));
         unit_valid[i] = (cnt_q[i] != '0);
         pop[i]        = unit_valid[i] && unit_ready[i];
         unit_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][rd_ptr_q[i]];
         unit_count[i*CNT_W +: CNT_W]          = cnt_q[i];
         if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
         if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
         if (push[i] && !pop[i]) cnt_d[i] = cnt_q[i] + 1'b1;
         else if (!push[i] && pop[i]) cnt_d[i] = cnt_q[i] - 1'b1;
      end
   end

   // Storage is not reset: only entries covered by a nonzero count are ever observed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data;
      end
   end

   // Commit merge
   logic [UNIT_BITS-1:0]     rr_ptr_q, rr_ptr_d, gnt_idx;
   logic [2*NUM_UNITS-1:0]   req_dbl;
   logic [NUM_UNITS-1:0]     req_rot;
   logic                     gnt_found, load;
   logic [CDATA_WIDTH-1:0]   gnt_data;
   logic                     cmt_valid_q, cmt_valid_d;
   logic [CDATA_WIDTH-1:0]   cmt_data_q, cmt_data_d;
   logic [UNIT_BITS-1:0]     cmt_unit_q, cmt_unit_d;
   logic                     bad_q, bad_d, ebreak_q, ebreak_d;

   assign load = !cmt_valid_q || cmt_out_ready;

   always_comb begin
      // Rotate requests so bit k corresponds to unit (rr_ptr + k) mod NUM_UNITS.
      req_dbl   = {cmt_in_valid, cmt_in_valid} >> rr_ptr_q;
      req_rot   = req_dbl[NUM_UNITS-1:0];
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
         if (!gnt_found && req_rot[k]) begin
            gnt_found = 1'b1;
            gnt_idx   = UNIT_BITS'((32'(rr_ptr_q) + k) % NUM_UNITS);
         end
      end
      gnt_data     = '0;
      cmt_in_ready = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (gnt_idx == UNIT_BITS'(i)) gnt_data = cmt_in_data[i*CDATA_WIDTH +: CDATA_WIDTH];
         cmt_in_ready[i] = reset_n && load && gnt_found && (gnt_idx == UNIT_BITS'(i));
      end
   end

   always_comb begin
      cmt_valid_d = cmt_valid_q;
      cmt_data_d  = cmt_data_q;
      cmt_unit_d  = cmt_unit_q;
      rr_ptr_d    = rr_ptr_q;
      if (load) begin
         cmt_valid_d = gnt_found;
         if (gnt_found) begin
            cmt_data_d = gnt_data;
            cmt_unit_d = gnt_idx;
            rr_ptr_d   = UNIT_BITS'((32'(gnt_idx) + 1) % NUM_UNITS);
         end
      end
      // A dropped bad-unit beat is still accepted, so it can set sim_ebreak too.
      bad_d    = bad_q || (in_valid && bad_unit);
      ebreak_d = ebreak_q || (in_valid && in_ready && in_ebreak);
   end

   assign cmt_out_valid = cmt_valid_q;
   assign cmt_out_data  = cmt_data_q;
   assign cmt_out_unit  = cmt_unit_q;
   assign bad_unit_err  = bad_q;
   assign sim_ebreak    = ebreak_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         rr_ptr_q    <= '0;
         cmt_valid_q <= 1'b0;
         cmt_data_q  <= '0;
         cmt_unit_q  <= '0;
         bad_q       <= 1'b0;
         ebreak_q    <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         cmt_valid_q <= cmt_valid_d;
         cmt_data_q  <= cmt_data_d;
         cmt_unit_q  <= cmt_unit_d;
         bad_q       <= bad_d;
         ebreak_q    <= ebreak_d;
      end
   end

endmodule

// File: tb/tb_vx_exec_route_arb.sv
// Bench for vx_exec_route_arb: scoreboard queues fed by a reference model at stimulus time,
// drained by an independent monitor whenever the DUT presents a FIFO head or a commit.
// A second instance with three units exercises the out-of-range dispatch path.
module tb_vx_exec_route_arb;

   localparam int N    = 4;
   localparam int D    = 4;
   localparam int DW   = 64;
   localparam int CW   = 48;
   localparam int UB   = 2;
   localparam int CNTW = 3;
   localparam int N2   = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset_n;
   logic              in_valid, in_ready, in_ebreak;
   logic [UB-1:0]     in_unit;
   logic [DW-1:0]     in_data;
   logic [N-1:0]      unit_valid, unit_ready;
   logic [N*DW-1:0]   unit_data;
   logic [N*CNTW-1:0] unit_count;
   logic [N-1:0]      cmt_in_valid, cmt_in_ready;
   logic [N*CW-1:0]   cmt_in_data;
   logic              cmt_out_valid, cmt_out_ready;
   logic [CW-1:0]     cmt_out_data;
   logic [UB-1:0]     cmt_out_unit;
   logic              bad_unit_err, sim_ebreak;

   logic               d2_in_valid, d2_in_ready, d2_in_ebreak;
   logic [UB-1:0]      d2_in_unit;
   logic [DW-1:0]      d2_in_data;
   logic [N2-1:0]      d2_unit_valid, d2_unit_ready;
   logic [N2*DW-1:0]   d2_unit_data;
   logic [N2*CNTW-1:0] d2_unit_count;
   logic [N2-1:0]      d2_cmt_in_valid, d2_cmt_in_ready;
   logic [N2*CW-1:0]   d2_cmt_in_data;
   logic               d2_cmt_out_valid, d2_cmt_out_ready;
   logic [CW-1:0]      d2_cmt_out_data;
   logic [UB-1:0]      d2_cmt_out_unit;
   logic               d2_bad_unit_err, d2_sim_ebreak;

   vx_exec_route_arb #(.NUM_UNITS(N), .DEPTH(D), .DATA_WIDTH(DW), .CDATA_WIDTH(CW)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_unit(in_unit),
      .in_ebreak(in_ebreak), .in_data(in_data),
      .unit_valid(unit_valid), .unit_ready(unit_ready), .unit_data(unit_data),
      .unit_count(unit_count),
      .cmt_in_valid(cmt_in_valid), .cmt_in_ready(cmt_in_ready), .cmt_in_data(cmt_in_data),
      .cmt_out_valid(cmt_out_valid), .cmt_out_ready(cmt_out_ready),
      .cmt_out_data(cmt_out_data), .cmt_out_unit(cmt_out_unit),
      .bad_unit_err(bad_unit_err), .sim_ebreak(sim_ebreak)
   );

   vx_exec_route_arb #(.NUM_UNITS(N2), .DEPTH(D), .DATA_WIDTH(DW), .CDATA_WIDTH(CW)) dut2 (
      .clk(clk), .reset_n(reset_n),
      .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_unit(d2_in_unit),
      .in_ebreak(d2_in_ebreak), .in_data(d2_in_data),
      .unit_valid(d2_unit_valid), .unit_ready(d2_unit_ready), .unit_data(d2_unit_data),
      .unit_count(d2_unit_count),
      .cmt_in_valid(d2_cmt_in_valid), .cmt_in_ready(d2_cmt_in_ready),
      .cmt_in_data(d2_cmt_in_data),
      .cmt_out_valid(d2_cmt_out_valid), .cmt_out_ready(d2_cmt_out_ready),
      .cmt_out_data(d2_cmt_out_data), .cmt_out_unit(d2_cmt_out_unit),
      .bad_unit_err(d2_bad_unit_err), .sim_ebreak(d2_sim_ebreak)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   typedef struct packed {
      logic [CW-1:0] data;
      logic [UB-1:0] unit;
   } cmt_t;

   logic [DW-1:0] uq [N][$];
   cmt_t          cq [$];
   int            mcnt [N];
   bit            mvalid;
   int            mptr;
   bit            mebreak;
   bit            mon_en = 1'b0;

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         uq[i].delete();
         mcnt[i] = 0;
      end
      cq.delete();
      mvalid  = 1'b0;
      mptr    = 0;
      mebreak = 1'b0;
   endtask

   // Called just before a rising edge with this cycle's inputs applied.
   task automatic model_step();
      bit            exp_rdy, load, found;
      int            g;
      logic [N-1:0]  exp_cin;
      bit            pops [N];
      exp_rdy = (mcnt[in_unit] < D);
      chk("in_ready", in_ready, exp_rdy);
      for (int i = 0; i < N; i++) begin
         chk("unit_valid", unit_valid[i], mcnt[i] > 0);
         chk("unit_count", unit_count[i*CNTW +: CNTW], mcnt[i]);
         pops[i] = (mcnt[i] > 0) && unit_ready[i];
      end
      chk("sim_ebreak", sim_ebreak, mebreak);
      chk("bad_unit_err", bad_unit_err, 0);
      chk("cmt_out_valid", cmt_out_valid, mvalid);
      for (int i = 0; i < N; i++) if (pops[i]) mcnt[i]--;
      if (in_valid && exp_rdy) begin
         mcnt[in_unit]++;
         uq[in_unit].push_back(in_data);
         if (in_ebreak) mebreak = 1'b1;
      end
      load  = !mvalid || cmt_out_ready;
      found = 1'b0;
      g     = 0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (mptr + k) % N;
         if (!found && cmt_in_valid[idx]) begin
            found = 1'b1;
            g     = idx;
         end
      end
      exp_cin = '0;
      if (load && found) exp_cin[g] = 1'b1;
      chk("cmt_in_ready", cmt_in_ready, exp_cin);
      if (load) begin
         mvalid = found;
         if (found) begin
            cq.push_back('{data: cmt_in_data[g*CW +: CW], unit: UB'(g)});
            mptr = (g + 1) % N;
         end
      end
   endtask

   // Monitor: compares every presented head against the scoreboard, pops on a handshake.
   always @(negedge clk) begin
      if (mon_en && reset_n) begin
         for (int i = 0; i < N; i++) begin
            if (unit_valid[i]) begin
               if (uq[i].size() == 0) chk("unit_extra", 1, 0);
               else begin
                  chk("unit_data", unit_data[i*DW +: DW], uq[i][0]);
                  if (unit_ready[i]) void'(uq[i].pop_front());
               end
            end
         end
         if (cmt_out_valid) begin
            if (cq.size() == 0) chk("cmt_extra", 1, 0);
            else begin
               chk("cmt_out", {cmt_out_data, cmt_out_unit}, cq[0]);
               if (cmt_out_ready) void'(cq.pop_front());
            end
         end
      end
   end

   task automatic idle_inputs();
      in_valid      = 1'b0;
      in_unit       = '0;
      in_ebreak     = 1'b0;
      in_data       = '0;
      unit_ready    = '0;
      cmt_in_valid  = '0;
      cmt_in_data   = '0;
      cmt_out_ready = 1'b0;
   endtask

   task automatic rand_cmt_data();
      for (int i = 0; i < N; i++) cmt_in_data[i*CW +: CW] = {$urandom, $urandom};
   endtask

   // One clock: inputs already applied, model at the falling edge, then advance past the edge.
   task automatic cycle();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_cycle();
      in_valid      = ($urandom_range(0, 2) != 0);
      in_unit       = UB'($urandom_range(0, N - 1));
      in_ebreak     = ($urandom_range(0, 31) == 0);
      in_data       = {$urandom, $urandom};
      unit_ready    = N'($urandom);
      cmt_in_valid  = N'($urandom);
      rand_cmt_data();
      cmt_out_ready = ($urandom_range(0, 3) != 0);
      cycle();
   endtask

   initial begin
      reset_n          = 1'b0;
      idle_inputs();
      d2_in_valid      = 1'b0;
      d2_in_unit       = '0;
      d2_in_ebreak     = 1'b0;
      d2_in_data       = '0;
      d2_unit_ready    = '0;
      d2_cmt_in_valid  = '0;
      d2_cmt_in_data   = '0;
      d2_cmt_out_ready = 1'b0;
      model_clear();
      #3;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_unit_valid", unit_valid, 0);
      chk("rst_cmt_out_valid", cmt_out_valid, 0);
      chk("rst_cmt_in_ready", cmt_in_ready, 0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // Out-of-range dispatch on the three-unit instance
      @(negedge clk);
      chk("d2_bad_init", d2_bad_unit_err, 0);
      @(posedge clk);
      #1;
      d2_in_valid  = 1'b1;
      d2_in_unit   = 2'd3;
      d2_in_ebreak = 1'b1;
      d2_in_data   = 64'hdead_beef;
      @(negedge clk);
      chk("d2_in_ready_bad", d2_in_ready, 1);
      @(posedge clk);
      #1;
      d2_in_valid = 1'b0;
      chk("d2_bad_unit_err", d2_bad_unit_err, 1);
      chk("d2_sim_ebreak", d2_sim_ebreak, 1);
      chk("d2_unit_count", d2_unit_count, 0);
      chk("d2_unit_valid", d2_unit_valid, 0);

      // Fill unit 2, then probe ready for unit 2 (full) and unit 0 (empty)
      for (int b = 0; b < D; b++) begin
         in_valid = 1'b1;
         in_unit  = 2'd2;
         in_data  = 64'h2000 + 64'(b);
         cycle();
      end
      chk("cnt2_full", unit_count[2*CNTW +: CNTW], D);
      in_unit = 2'd2;
      in_data = 64'h2fff;
      cycle();
      in_unit = 2'd0;
      in_data = 64'h0001;
      cycle();

      // Fill unit 1, then pop while pushing to the full unit
      for (int b = 0; b < D; b++) begin
         in_unit = 2'd1;
         in_data = 64'h1000 + 64'(b);
         cycle();
      end
      in_unit    = 2'd1;
      in_data    = 64'h1ff0;
      unit_ready = 4'b0010;
      cycle();
      unit_ready = '0;
      in_data    = 64'h1ff1;
      cycle();
      in_valid   = 1'b0;
      unit_ready = '1;
      repeat (6) cycle();

      // Round-robin under saturation, then a three-cycle stall
      cmt_in_valid  = '1;
      cmt_out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         rand_cmt_data();
         cycle();
      end
      cmt_out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         rand_cmt_data();
         cycle();
      end
      cmt_out_ready = 1'b1;
      cmt_in_valid  = '0;
      repeat (3) cycle();

      repeat (400) rand_cycle();

      // Build up state, then reset asynchronously between edges
      idle_inputs();
      cmt_in_valid = 4'b0101;
      rand_cmt_data();
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'b1;
         in_unit  = UB'(c % N);
         in_data  = {$urandom, $urandom};
         cycle();
      end
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_unit_valid", unit_valid, 0);
      chk("mid_rst_unit_count", unit_count, 0);
      chk("mid_rst_cmt_valid", cmt_out_valid, 0);
      chk("mid_rst_cmt_data", cmt_out_data, 0);
      chk("mid_rst_cmt_unit", cmt_out_unit, 0);
      chk("mid_rst_cmt_in_ready", cmt_in_ready, 0);
      model_clear();
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      unit_ready    = '1;
      cmt_out_ready = 1'b1;
      repeat (3) cycle();

      repeat (200) rand_cycle();

      idle_inputs();
      unit_ready    = '1;
      cmt_out_ready = 1'b1;
      repeat (10) cycle();
      for (int i = 0; i < N; i++) chk("unit_drain", uq[i].size(), 0);
      chk("cmt_drain", cq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net against a stalled run
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
